// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU sequencer and its register file.
package fpu_pkg;

  localparam int FP_WIDTH = 32;

  // Operation codes presented by the core; codes 5-7 are illegal.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_MOV  = 3'd4,
    OP_ILL5 = 3'd5,
    OP_ILL6 = 3'd6,
    OP_ILL7 = 3'd7
  } fp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WB
  } fpu_state_e;

  // True for operations that are dispatched to an external arithmetic unit.
  function automatic logic op_is_unit(input fp_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // True for the reserved opcode range.
  function automatic logic op_is_illegal(input fp_op_e op);
    return (op == OP_ILL5) || (op == OP_ILL6) || (op == OP_ILL7);
  endfunction

endpackage

// File: rtl/fpu_regfile.sv
// FP register file: two write ports (port 0 wins on an address clash) and
// three combinational read ports. Cleared synchronously on reset.
module fpu_regfile
  import fpu_pkg::*;
#(
  parameter int WIDTH = FP_WIDTH,
  parameter int NREG  = 32,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] mem [NREG];

  // Register array update; port 1 is suppressed when port 0 targets the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we1 && !(we0 && (waddr0 == waddr1))) begin
        mem[waddr1] <= wdata1;
      end
      if (we0) begin
        mem[waddr0] <= wdata0;
      end
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/fpu_seq.sv
// Multi-cycle FPU sequencer: accepts one FP op from the core, dispatches it to
// the add/mul/div units, waits for the result and writes it back.
module fpu_seq
  import fpu_pkg::*;
#(
  parameter int WIDTH   = FP_WIDTH,
  parameter int NREG    = 32,
  parameter int TIMEOUT = 64,
  localparam int AW     = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [AW-1:0]    req_rd,
  input  logic [AW-1:0]    req_rs,
  input  logic [AW-1:0]    req_rt,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             add_start,
  output logic             mul_start,
  output logic             div_start,
  output logic             add_sub,
  input  logic             add_valid,
  input  logic [WIDTH-1:0] add_data,
  input  logic             mul_valid,
  input  logic [WIDTH-1:0] mul_data,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_data
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  fpu_state_e       state, state_nxt;
  fp_op_e           op_q;
  logic [AW-1:0]    rd_q, rs_q, rt_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             timeout_hit;
  logic             wb_we;
  logic [AW-1:0]    rt_addr;
  logic [WIDTH-1:0] rs_data, rt_data;

  // While idle the rt port follows the incoming request so MOV can latch its source at accept.
  assign rt_addr = (state == ST_IDLE) ? req_rt : rt_q;
  assign wb_we   = (state == ST_WB) && !op_is_illegal(op_q);

  fpu_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .AW    (AW)
  ) u_regfile (
    .clk    (CLK),
    .rst    (RST),
    .we0    (wb_we),
    .waddr0 (rd_q),
    .wdata0 (res_q),
    .we1    (wr_en),
    .waddr1 (wr_addr),
    .wdata1 (wr_data),
    .raddr0 (rs_q),
    .raddr1 (rt_addr),
    .raddr2 (rd_addr),
    .rdata0 (rs_data),
    .rdata1 (rt_data),
    .rdata2 (rd_data)
  );

  // Pick the valid/data pair of the unit the current operation was sent to.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        sel_valid = add_valid;
        sel_data  = add_data;
      end
      OP_MUL: begin
        sel_valid = mul_valid;
        sel_data  = mul_data;
      end
      OP_DIV: begin
        sel_valid = div_valid;
        sel_data  = div_data;
      end
      default: begin
        sel_valid = 1'b0;
        sel_data  = '0;
      end
    endcase
  end

  assign timeout_hit = (state == ST_WAIT) && !sel_valid && (cnt == CW'(TIMEOUT - 1));

  // Next-state logic and per-state handshake/start/done outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    add_start = 1'b0;
    mul_start = 1'b0;
    div_start = 1'b0;
    add_sub   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = !RST;
        if (req_valid) begin
          state_nxt = op_is_unit(fp_op_e'(req_op)) ? ST_ISSUE : ST_WB;
        end
      end
      ST_ISSUE: begin
        add_sub   = (op_q == OP_SUB);
        add_start = (op_q == OP_ADD) || (op_q == OP_SUB);
        mul_start = (op_q == OP_MUL);
        div_start = (op_q == OP_DIV);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        add_sub = (op_q == OP_SUB);
        if (sel_valid) begin
          state_nxt = ST_WB;
        end else if (timeout_hit) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WB: begin
        add_sub   = (op_q == OP_SUB);
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus request latching, operand capture, timeout counting and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      op_q  <= OP_ADD;
      rd_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      res_q <= '0;
      op_a  <= '0;
      op_b  <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q <= fp_op_e'(req_op);
            rd_q <= req_rd;
            rs_q <= req_rs;
            rt_q <= req_rt;
            if (fp_op_e'(req_op) == OP_MOV) begin
              res_q <= rt_data;
            end
          end
        end
        ST_ISSUE: begin
          op_a <= rs_data;
          op_b <= rt_data;
          cnt  <= '0;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (sel_valid) begin
            res_q <= sel_data;
          end else if (timeout_hit) begin
            err <= 1'b1;
          end
        end
        ST_WB: begin
          if (op_is_illegal(op_q)) begin
            err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_seq.sv
// Scoreboard-driven bench for fpu_seq: expected writebacks are queued when an
// op is issued and retired/compared when the sequencer pulses done.
module tb_fpu_seq;
  import fpu_pkg::*;

  localparam int W  = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int TO = 40;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [AW-1:0] req_rd = '0, req_rs = '0, req_rt = '0;
  logic          busy, done, err;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data, op_a, op_b;
  logic          add_start, mul_start, div_start, add_sub;
  logic          add_valid = 1'b0, mul_valid = 1'b0, div_valid = 1'b0;
  logic [W-1:0]  add_data = '0, mul_data = '0, div_data = '0;

  fpu_seq #(.WIDTH(W), .NREG(NR), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt),
    .busy(busy), .done(done), .err(err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .op_a(op_a), .op_b(op_b),
    .add_start(add_start), .mul_start(mul_start), .div_start(div_start), .add_sub(add_sub),
    .add_valid(add_valid), .add_data(add_data),
    .mul_valid(mul_valid), .mul_data(mul_data),
    .div_valid(div_valid), .div_data(div_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] rd;
    logic [W-1:0]  data;
    bit            write;
    bit            err;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [NR];
  bit           errExp;
  int           testsRun = 0;
  int           testsFailed = 0;
  int           startCount = 0;

  // Count every start pulse so ops that must not touch a unit can be checked.
  always @(negedge CLK) begin
    if (!RST) startCount = startCount + int'(add_start) + int'(mul_start) + int'(div_start);
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic coreWrite(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // Present one request for one cycle (optionally with a core write) and queue its expected retirement.
  task automatic applyStimulus(input fp_op_e op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                               input logic [AW-1:0] rt, input bit wrIn, input logic [AW-1:0] wrA,
                               input logic [W-1:0] wrD, input logic [W-1:0] unitData, input bit timesOut);
    exp_t e;
    bit   illegal;
    illegal = (op == OP_ILL5) || (op == OP_ILL6) || (op == OP_ILL7);
    e.rd    = rd;
    e.data  = (op == OP_MOV) ? model[rt] : unitData;
    e.write = !illegal && !timesOut;
    e.err   = errExp || illegal || timesOut;
    sb.push_back(e);
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_rd = rd; req_rs = rs; req_rt = rt;
    if (wrIn) begin wr_en = 1'b1; wr_addr = wrA; wr_data = wrD; end
    tick();
    req_valid = 1'b0;
    wr_en = 1'b0;
    if (wrIn) model[wrA] = wrD;
  endtask

  // From the ISSUE cycle, act as the selected unit: return data 'delay' cycles after start.
  task automatic driveUnit(input int which, input int delay, input logic [W-1:0] data, input bit spurious,
                           input logic [W-1:0] expA, input logic [W-1:0] expB);
    logic [2:0] startExp;
    startExp = 3'b100 >> which;
    checkOutput("start_vec", {add_start, mul_start, div_start}, startExp);
    checkOutput("busy_issue", busy, 1);
    for (int c = 2; c <= delay + 1; c++) begin
      tick();
      add_valid = 1'b0; mul_valid = 1'b0; div_valid = 1'b0;
      if (c == 2) begin
        checkOutput("op_a", op_a, expA);
        checkOutput("op_b", op_b, expB);
        checkOutput("req_ready_wait", req_ready, 0);
      end
      if (c == delay + 1) begin
        case (which)
          0: begin add_valid = 1'b1; add_data = data; end
          1: begin mul_valid = 1'b1; mul_data = data; end
          default: begin div_valid = 1'b1; div_data = data; end
        endcase
      end else if (spurious && (c % 4 == 0)) begin
        if (which != 0) begin add_valid = 1'b1; add_data = 32'hBAD0_0001; end
        if (which != 1) begin mul_valid = 1'b1; mul_data = 32'hBAD0_0002; end
      end
    end
    tick();
    add_valid = 1'b0; mul_valid = 1'b0; div_valid = 1'b0;
  endtask

  // Bounded wait for done; checks the cycle (counted from accept) at which it appears.
  task automatic waitDone(input string tag, input int startCycle, input int expCycle, input int budget);
    int cyc;
    cyc = startCycle;
    while (!done && (cyc < startCycle + budget)) begin
      tick();
      cyc++;
    end
    if (!done) checkOutput({tag, " done_seen"}, 0, 1);
    else begin
      checkOutput({tag, " latency"}, cyc, expCycle);
      checkOutput({tag, " req_ready_at_done"}, req_ready, 0);
    end
  endtask

  // Called in the done cycle: pop the scoreboard, optionally collide a core write, then compare.
  task automatic retire(input string tag, input bit coreWr, input logic [AW-1:0] coreA, input logic [W-1:0] coreD);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, " sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    if (coreWr) begin wr_en = 1'b1; wr_addr = coreA; wr_data = coreD; end
    tick();
    wr_en = 1'b0;
    if (coreWr && !(e.write && coreA == e.rd)) model[coreA] = coreD;
    if (e.write) model[e.rd] = e.data;
    errExp = e.err;
    checkOutput({tag, " done_low_after"}, done, 0);
    checkOutput({tag, " req_ready_after"}, req_ready, 1);
    checkOutput({tag, " err"}, err, e.err);
    rd_addr = e.rd;
    #1;
    checkOutput({tag, " rd_data"}, rd_data, model[e.rd]);
    if (coreWr) begin
      rd_addr = coreA;
      #1;
      checkOutput({tag, " core_addr"}, rd_data, model[coreA]);
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < NR; i++) begin
      rd_addr = AW'(i);
      #1;
      checkOutput(tag, rd_data, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc;
    for (int i = 0; i < NR; i++) model[i] = '0;
    errExp = 1'b0;

    // Reset state
    repeat (3) tick();
    checkOutput("req_ready_in_reset", req_ready, 0);
    RST = 1'b0;
    #1;
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_op_a", op_a, 0);
    checkOutput("rst_op_b", op_b, 0);
    checkOutput("rst_starts", {add_start, mul_start, div_start, add_sub}, 0);
    checkAllZero("rst_freg");

    coreWrite(5'd1, 32'h3F80_0000);
    coreWrite(5'd2, 32'h4000_0000);

    // ADD, result two cycles after start: done 4 cycles after accept
    applyStimulus(OP_ADD, 5'd3, 5'd1, 5'd2, 0, '0, '0, 32'h4040_0000, 0);
    driveUnit(0, 2, 32'h4040_0000, 0, model[1], model[2]);
    waitDone("add", 4, 4, 8);
    retire("add", 0, '0, '0);

    // MOV: done in the cycle after accept, no unit started
    sc = startCount;
    applyStimulus(OP_MOV, 5'd5, 5'd0, 5'd1, 0, '0, '0, '0, 0);
    waitDone("mov", 1, 1, 4);
    retire("mov", 0, '0, '0);
    checkOutput("mov_no_start", startCount, sc);

    // SUB with a core write to rs in the accept cycle; add_sub held through the op
    applyStimulus(OP_SUB, 5'd6, 5'd7, 5'd1, 1, 5'd7, 32'h40A0_0000, 32'h4080_0000, 0);
    checkOutput("sub_add_sub_issue", add_sub, 1);
    driveUnit(0, 1, 32'h4080_0000, 0, model[7], model[1]);
    waitDone("sub", 3, 3, 4);
    checkOutput("sub_add_sub_wb", add_sub, 1);
    retire("sub", 0, '0, '0);

    // DIV, valid 30 cycles after start, other units chatter meanwhile
    applyStimulus(OP_DIV, 5'd8, 5'd2, 5'd1, 0, '0, '0, 32'h3F00_0000, 0);
    driveUnit(2, 30, 32'h3F00_0000, 1, model[2], model[1]);
    waitDone("div", 32, 32, 4);
    retire("div", 0, '0, '0);

    // Writeback clashes with a core write to the same register: writeback wins
    applyStimulus(OP_ADD, 5'd3, 5'd1, 5'd1, 0, '0, '0, 32'h1234_5678, 0);
    driveUnit(0, 1, 32'h1234_5678, 0, model[1], model[1]);
    waitDone("wb_clash", 3, 3, 4);
    retire("wb_clash", 1, 5'd3, 32'hDEAD_BEEF);

    // Writeback alongside a core write to another register: both land
    applyStimulus(OP_ADD, 5'd3, 5'd2, 5'd2, 0, '0, '0, 32'h0BAD_F00D, 0);
    driveUnit(0, 3, 32'h0BAD_F00D, 0, model[2], model[2]);
    waitDone("wb_split", 5, 5, 4);
    retire("wb_split", 1, 5'd4, 32'hDEAD_BEEF);

    // MUL that never answers: abort after TO wait cycles with err, no write
    applyStimulus(OP_MUL, 5'd10, 5'd1, 5'd2, 0, '0, '0, '0, 1);
    checkOutput("mul_start", {add_start, mul_start, div_start}, 3'b010);
    waitDone("mul_timeout", 1, 1 + TO, TO + 8);
    retire("mul_timeout", 0, '0, '0);

    // Sequencer still accepts work after the abort
    applyStimulus(OP_MOV, 5'd11, 5'd0, 5'd2, 0, '0, '0, '0, 0);
    waitDone("mov_after_to", 1, 1, 4);
    retire("mov_after_to", 0, '0, '0);

    // Reset in the middle of a DIV wait
    applyStimulus(OP_DIV, 5'd3, 5'd1, 5'd2, 0, '0, '0, '0, 0);
    checkOutput("rst_div_start", div_start, 1);
    repeat (3) begin
      tick();
      checkOutput("rst_div_no_done", done, 0);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sb.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    errExp = 1'b0;
    #1;
    checkOutput("midrst_req_ready", req_ready, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_err", err, 0);
    div_valid = 1'b1; div_data = 32'h7777_7777;
    tick();
    div_valid = 1'b0;
    checkOutput("late_valid_done", done, 0);
    checkOutput("late_valid_busy", busy, 0);
    checkAllZero("midrst_freg");

    // Illegal opcode: accepted, no write, err rises
    sc = startCount;
    applyStimulus(fp_op_e'(3'd6), 5'd9, 5'd0, 5'd0, 0, '0, '0, 32'hFFFF_FFFF, 0);
    waitDone("illegal", 1, 1, 4);
    retire("illegal", 0, '0, '0);
    checkOutput("illegal_no_start", startCount, sc);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
